// File: rtl/matmul_seq_ctrl.sv
// Sequencer for C = A x B: walks (i,j,k), drives A/B read addresses, MAC strobes and C writes.
// Registered outputs; each element takes N + RD_LAT + 2 cycles; start is ignored while busy (no backpressure).
module matmul_seq_ctrl #(
    parameter int N      = 4,
    parameter int RD_LAT = 1,
    parameter int AW     = $clog2(N * N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] a_addr,
    output logic [AW-1:0] b_addr,
    output logic          mac_clr,
    output logic          mac_en,
    output logic [AW-1:0] c_addr,
    output logic          c_we
);

    localparam int            CW         = $clog2(N);
    localparam logic [CW-1:0] LAST_IDX   = CW'(N - 1);
    localparam logic [AW-1:0] N_AW       = AW'(N);
    localparam logic [1:0]    DRAIN_LAST = (RD_LAT > 0) ? 2'(RD_LAT - 1) : 2'd0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_ACC,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_i;
    logic [CW-1:0] r_j;
    logic [CW-1:0] r_k;
    logic [CW-1:0] w_i_nxt;
    logic [CW-1:0] w_j_nxt;
    logic [CW-1:0] w_k_nxt;
    logic [1:0]    r_dcnt;
    logic [1:0]    w_dcnt_nxt;

    logic          r_busy;
    logic          r_done;
    logic          r_clr;
    logic          r_issue;
    logic          r_we;
    logic [AW-1:0] r_a_addr;
    logic [AW-1:0] r_b_addr;
    logic [AW-1:0] r_c_addr;
    logic          w_busy_nxt;
    logic          w_done_nxt;
    logic          w_clr_nxt;
    logic          w_issue_nxt;
    logic          w_we_nxt;
    logic [AW-1:0] w_a_addr_nxt;
    logic [AW-1:0] w_b_addr_nxt;
    logic [AW-1:0] w_c_addr_nxt;

    // r_k always holds the k issued in the current ACC cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_i_nxt     = r_i;
        w_j_nxt     = r_j;
        w_k_nxt     = r_k;
        w_dcnt_nxt  = r_dcnt;
        case (r_state)
            S_IDLE: begin
                w_i_nxt = '0;
                w_j_nxt = '0;
                w_k_nxt = '0;
                if (start) begin
                    w_state_nxt = S_CLR;
                end
            end
            S_CLR: begin
                w_k_nxt     = '0;
                w_state_nxt = S_ACC;
            end
            S_ACC: begin
                if (r_k == LAST_IDX) begin
                    w_dcnt_nxt  = '0;
                    w_state_nxt = (RD_LAT == 0) ? S_WRITE : S_DRAIN;
                end else begin
                    w_k_nxt = r_k + 1'b1;
                end
            end
            S_DRAIN: begin
                if (r_dcnt == DRAIN_LAST) begin
                    w_state_nxt = S_WRITE;
                end else begin
                    w_dcnt_nxt = r_dcnt + 1'b1;
                end
            end
            S_WRITE: begin
                w_state_nxt = S_CLR;
                if (r_j == LAST_IDX) begin
                    w_j_nxt = '0;
                    if (r_i == LAST_IDX) begin
                        w_i_nxt     = '0;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_i_nxt = r_i + 1'b1;
                    end
                end else begin
                    w_j_nxt = r_j + 1'b1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs are precomputed from the state being entered so they register in step with it.
    always_comb begin
        w_busy_nxt   = (w_state_nxt != S_IDLE);
        w_done_nxt   = (w_state_nxt == S_DONE);
        w_clr_nxt    = (w_state_nxt == S_CLR);
        w_issue_nxt  = (w_state_nxt == S_ACC);
        w_we_nxt     = (w_state_nxt == S_WRITE);
        w_a_addr_nxt = r_a_addr;
        w_b_addr_nxt = r_b_addr;
        w_c_addr_nxt = r_c_addr;
        if (w_issue_nxt) begin
            w_a_addr_nxt = AW'(w_i_nxt) * N_AW + AW'(w_k_nxt);
            w_b_addr_nxt = AW'(w_k_nxt) * N_AW + AW'(w_j_nxt);
        end
        if (w_we_nxt) begin
            w_c_addr_nxt = AW'(w_i_nxt) * N_AW + AW'(w_j_nxt);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_i      <= '0;
            r_j      <= '0;
            r_k      <= '0;
            r_dcnt   <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_clr    <= 1'b0;
            r_issue  <= 1'b0;
            r_we     <= 1'b0;
            r_a_addr <= '0;
            r_b_addr <= '0;
            r_c_addr <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_i      <= w_i_nxt;
            r_j      <= w_j_nxt;
            r_k      <= w_k_nxt;
            r_dcnt   <= w_dcnt_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_clr    <= w_clr_nxt;
            r_issue  <= w_issue_nxt;
            r_we     <= w_we_nxt;
            r_a_addr <= w_a_addr_nxt;
            r_b_addr <= w_b_addr_nxt;
            r_c_addr <= w_c_addr_nxt;
        end
    end

    // mac_en follows the issue flag by the memory read latency.
    generate
        if (RD_LAT == 0) begin : g_en_direct
            assign mac_en = r_issue;
        end else begin : g_en_pipe
            logic [RD_LAT-1:0] r_en_pipe;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_en_pipe <= '0;
                end else begin
                    r_en_pipe[0] <= r_issue;
                    for (int s = 1; s < RD_LAT; s++) begin
                        r_en_pipe[s] <= r_en_pipe[s-1];
                    end
                end
            end
            assign mac_en = r_en_pipe[RD_LAT-1];
        end
    endgenerate

    assign busy    = r_busy;
    assign done    = r_done;
    assign mac_clr = r_clr;
    assign c_we    = r_we;
    assign a_addr  = r_a_addr;
    assign b_addr  = r_b_addr;
    assign c_addr  = r_c_addr;

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Scoreboard bench for matmul_seq_ctrl: two instances (N=4/RD_LAT=1 and N=2/RD_LAT=0),
// expected event timelines planned from the start/reset stimulus, plus a memory/MAC model for C.
module tb_matmul_seq_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst4, start4, busy4, done4, clr4, en4, we4;
    logic [3:0] a4, b4, c4;
    logic rst2, start2, busy2, done2, clr2, en2, we2;
    logic [1:0] a2, b2, c2;

    matmul_seq_ctrl #(.N(4), .RD_LAT(1)) u_dut4 (
        .clk(clk), .rst(rst4), .start(start4), .busy(busy4), .done(done4),
        .a_addr(a4), .b_addr(b4), .mac_clr(clr4), .mac_en(en4), .c_addr(c4), .c_we(we4)
    );

    matmul_seq_ctrl #(.N(2), .RD_LAT(0)) u_dut2 (
        .clk(clk), .rst(rst2), .start(start2), .busy(busy2), .done(done2),
        .a_addr(a2), .b_addr(b2), .mac_clr(clr2), .mac_en(en2), .c_addr(c2), .c_we(we2)
    );

    typedef struct {
        int cyc;
        int val;
    } ev_t;

    // queue index = unit*5 + kind; kinds: 0 mac_clr, 1 mac_en, 2 c_we, 3 done, 4 address sample
    ev_t evq[10][$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  nd[2] = '{4, 2};
    int  rl[2] = '{1, 0};
    int  bs[2] = '{0, 0};
    int  be[2] = '{-1, -1};
    int  c0_last[2] = '{0, 0};
    int  amem[2][16];
    int  bmem[2][16];
    int  cmem[2][16];
    int  acc[2] = '{0, 0};
    int  prevp[2] = '{0, 0};
    int  n_we[2] = '{0, 0};
    int  n_en[2] = '{0, 0};
    bit  mon_on = 1'b0;

    task automatic check(input int u, input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL u%0d %s: got %0d expected %0d (cycle %0d)", u, name, act, exp, cyc);
        end
    endtask

    task automatic push(input int u, input int kind, input int c, input int v);
        ev_t e;
        e.cyc = c;
        e.val = v;
        evq[u*5+kind].push_back(e);
    endtask

    // Expected timeline of a whole run whose first CLR is cycle c0.
    task automatic plan_run(input int u, input int c0);
        int n, e, i, j, base;
        n = nd[u];
        e = n + rl[u] + 2;
        bs[u] = c0;
        be[u] = c0 + n*n*e;
        c0_last[u] = c0;
        for (int el = 0; el < n*n; el++) begin
            i = el / n;
            j = el % n;
            base = c0 + el*e;
            push(u, 0, base, 0);
            for (int k = 0; k < n; k++) begin
                push(u, 4, base + 1 + k, (i*n + k)*256 + k*n + j);
                push(u, 1, base + 1 + k + rl[u], 0);
            end
            push(u, 2, base + e - 1, el);
        end
        push(u, 3, c0 + n*n*e, 0);
    endtask

    task automatic flush(input int u, input int from);
        for (int k = 0; k < 5; k++)
            while (evq[u*5+k].size() > 0 && evq[u*5+k][$].cyc >= from)
                void'(evq[u*5+k].pop_back());
    endtask

    // Reference model: inputs sampled at each rising edge decide the next cycle.
    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            logic r, s;
            r = (u == 1) ? rst2 : rst4;
            s = (u == 1) ? start2 : start4;
            if (r) begin
                flush(u, cyc + 1);
                if (be[u] > cyc) be[u] = cyc;
            end else if (s && cyc > be[u]) begin
                plan_run(u, cyc + 1);
            end
        end
        cyc++;
    end

    task automatic ev(input int u, input int kind, input logic sig, input int val, input string name);
        ev_t e;
        int qi;
        qi = u*5 + kind;
        if (sig) begin
            if (evq[qi].size() == 0) begin
                checks++;
                errors++;
                $display("FAIL u%0d %s unexpected in cycle %0d", u, name, cyc);
            end else begin
                e = evq[qi].pop_front();
                check(u, {name, "_cycle"}, cyc, e.cyc);
                check(u, {name, "_val"}, val, e.val);
            end
        end else if (evq[qi].size() > 0 && evq[qi][0].cyc <= cyc) begin
            e = evq[qi].pop_front();
            checks++;
            errors++;
            $display("FAIL u%0d %s missing: got none, expected in cycle %0d", u, name, e.cyc);
        end
    endtask

    task automatic mon(input int u, input logic bz, input logic dn, input logic cl, input logic en,
                       input logic we, input int a, input int b, input int c);
        int cur, qi;
        ev_t e;
        cur = amem[u][a] * bmem[u][b];
        check(u, "busy", int'(bz), int'(cyc >= bs[u] && cyc <= be[u]));
        ev(u, 0, cl, 0, "mac_clr");
        ev(u, 1, en, 0, "mac_en");
        ev(u, 2, we, c, "c_we");
        ev(u, 3, dn, 0, "done");
        qi = u*5 + 4;
        while (evq[qi].size() > 0 && evq[qi][0].cyc < cyc) void'(evq[qi].pop_front());
        if (evq[qi].size() > 0 && evq[qi][0].cyc == cyc) begin
            e = evq[qi].pop_front();
            check(u, "a_b_addr", a*256 + b, e.val);
        end
        if (cl) acc[u] = 0;
        if (en) begin
            acc[u] += (rl[u] == 0) ? cur : prevp[u];
            n_en[u]++;
        end
        if (we) begin
            cmem[u][c] = acc[u];
            n_we[u]++;
        end
        prevp[u] = cur;
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            mon(0, busy4, done4, clr4, en4, we4, int'(a4), int'(b4), int'(c4));
            mon(1, busy2, done2, clr2, en2, we2, int'(a2), int'(b2), int'(c2));
        end
    end

    function automatic int outs(input int u);
        if (u == 1) return int'({busy2, done2, clr2, en2, we2, a2, b2, c2});
        return int'({busy4, done4, clr4, en4, we4, a4, b4, c4});
    endfunction

    task automatic new_mats(input int u);
        for (int x = 0; x < 16; x++) begin
            amem[u][x] = $urandom_range(0, 15);
            bmem[u][x] = $urandom_range(0, 15);
            cmem[u][x] = -1;
        end
        n_we[u] = 0;
        n_en[u] = 0;
    endtask

    task automatic gold(input int u);
        int n, r;
        n = nd[u];
        for (int i = 0; i < n; i++)
            for (int j = 0; j < n; j++) begin
                r = 0;
                for (int k = 0; k < n; k++) r += amem[u][i*n+k] * bmem[u][k*n+j];
                check(u, "C_elem", cmem[u][i*n+j], r);
            end
        check(u, "c_we_count", n_we[u], n*n);
        check(u, "mac_en_count", n_en[u], n*n*n);
    endtask

    task automatic wait_until(input int target);
        for (int g = 0; g < 5000 && cyc < target; g++) @(negedge clk);
        if (cyc < target) begin
            checks++;
            errors++;
            $display("FAIL wait_timeout: got cycle %0d expected %0d", cyc, target);
        end
    endtask

    task automatic pulse(input int u);
        if (u == 1) start2 = 1'b1; else start4 = 1'b1;
        @(negedge clk);
        if (u == 1) start2 = 1'b0; else start4 = 1'b0;
    endtask

    initial begin
        int c0f;
        rst4 = 1'b1; rst2 = 1'b1; start4 = 1'b0; start2 = 1'b0;
        new_mats(0);
        new_mats(1);
        repeat (2) @(negedge clk);
        check(0, "reset_outs", outs(0), 0);
        check(1, "reset_outs", outs(1), 0);
        rst4 = 1'b0; rst2 = 1'b0;
        mon_on = 1'b1;
        repeat (10) @(negedge clk);

        // full run with a start pulse mid-run that must be ignored
        new_mats(0);
        repeat ($urandom_range(1, 5)) @(negedge clk);
        pulse(0);
        wait_until(c0_last[0] + 30);
        pulse(0);
        wait_until(be[0] + 3);
        gold(0);

        // start held high: back-to-back runs one IDLE cycle apart
        new_mats(0);
        start4 = 1'b1;
        @(negedge clk);
        c0f = c0_last[0];
        wait_until(c0f + 114);
        start4 = 1'b0;
        n_we[0] = 0;
        n_en[0] = 0;
        wait_until(be[0] + 3);
        gold(0);

        // reset mid-run, then a clean run
        new_mats(0);
        pulse(0);
        wait_until(c0_last[0] + 40);
        rst4 = 1'b1;
        @(negedge clk);
        check(0, "mid_reset_outs", outs(0), 0);
        rst4 = 1'b0;
        repeat (30) @(negedge clk);
        new_mats(0);
        repeat ($urandom_range(0, 4)) @(negedge clk);
        pulse(0);
        wait_until(be[0] + 3);
        gold(0);

        // N=2, RD_LAT=0, including a random mid-run reset
        new_mats(1);
        pulse(1);
        wait_until(c0_last[1] + $urandom_range(1, 14));
        rst2 = 1'b1;
        @(negedge clk);
        check(1, "mid_reset_outs", outs(1), 0);
        rst2 = 1'b0;
        repeat (8) @(negedge clk);
        new_mats(1);
        pulse(1);
        wait_until(be[1] + 3);
        gold(1);

        repeat (5) @(negedge clk);
        for (int q = 0; q < 10; q++) check(q / 5, "leftover_events", evq[q].size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
